// File: rtl/systolic_mm_sched.sv
// Sequencer for an N x N systolic array: latches A and B, clears the PE accumulators,
// feeds the skewed operand wavefront on the left/top edges, then flags completion.
module systolic_mm_sched #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned N          = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [N*N*DATA_WIDTH-1:0]    a_flat_i,
   input  logic [N*N*DATA_WIDTH-1:0]    b_flat_i,
   output logic                         ready_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         pe_clr_o,
   output logic [N*DATA_WIDTH-1:0]      left_o,
   output logic [N*DATA_WIDTH-1:0]      up_o
);

   localparam int unsigned TW = $clog2(3 * N - 1);
   localparam logic [TW-1:0] TLast = TW'(3 * N - 3);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StFlush,
      StDone
   } state_e;

   state_e                    state_q, state_d;
   logic [TW-1:0]             t_q, t_d;
   logic [N*N*DATA_WIDTH-1:0] a_q, b_q;
   logic                      load;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         if (load) begin
            a_q <= a_flat_i;
            b_q <= b_flat_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            t_d = '0;
            if (start_i) begin
               state_d = StClear;
               load    = 1'b1;
            end
         end
         StClear: begin
            state_d = StFeed;
            t_d     = '0;
         end
         StFeed: begin
            if (t_q == TLast) begin
               state_d = StFlush;
               t_d     = '0;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         StFlush: state_d = StDone;
         StDone:  state_d = StIdle;
         default: begin
            state_d = StIdle;
            t_d     = '0;
         end
      endcase
      // Abort only cancels an in-flight job; start in IDLE has priority.
      if (abort_i && (state_q == StClear || state_q == StFeed || state_q == StFlush)) begin
         state_d = StIdle;
         t_d     = '0;
         load    = 1'b0;
      end
   end

   assign ready_o  = (state_q == StIdle);
   assign busy_o   = (state_q == StClear) || (state_q == StFeed) || (state_q == StFlush);
   assign done_o   = (state_q == StDone);
   assign pe_clr_o = (state_q == StClear);

   // Lane i carries element k of its row/column at step t = i + k; all other lanes are zero.
   always_comb begin
      left_o = '0;
      up_o   = '0;
      if (state_q == StFeed) begin
         for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < N; k++) begin
               if (t_q == TW'(i + k)) begin
                  left_o[i*DATA_WIDTH +: DATA_WIDTH] = a_q[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
                  up_o[i*DATA_WIDTH +: DATA_WIDTH]   = b_q[(k*N+i)*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_systolic_mm_sched.sv
// Bench for systolic_mm_sched: N=2 and N=4 instances, each driving a behavioural PE array,
// with a scoreboard of expected C matrices checked whenever done_o pulses.
module tb_systolic_mm_sched;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic                s2, a2, rdy2, bsy2, dn2, clr2;
   logic [4*DW-1:0]     af2, bf2;
   logic [2*DW-1:0]     l2, u2;
   logic                s4, a4, rdy4, bsy4, dn4, clr4;
   logic [16*DW-1:0]    af4, bf4;
   logic [4*DW-1:0]     l4, u4;

   systolic_mm_sched #(.DATA_WIDTH(DW), .N(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s2), .abort_i(a2), .a_flat_i(af2), .b_flat_i(bf2),
      .ready_o(rdy2), .busy_o(bsy2), .done_o(dn2), .pe_clr_o(clr2), .left_o(l2), .up_o(u2));

   systolic_mm_sched #(.DATA_WIDTH(DW), .N(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(s4), .abort_i(a4), .a_flat_i(af4), .b_flat_i(bf4),
      .ready_o(rdy4), .busy_o(bsy4), .done_o(dn4), .pe_clr_o(clr4), .left_o(l4), .up_o(u4));

   // Behavioural PE arrays: accumulate up*left, forward operands right/down one cycle later.
   logic [63:0]   res2 [2][2];
   logic [DW-1:0] h2 [2][2], v2 [2][2], lin2 [2][2], uin2 [2][2];
   logic [63:0]   res4 [4][4];
   logic [DW-1:0] h4 [4][4], v4 [4][4], lin4 [4][4], uin4 [4][4];
   logic [1023:0] got2, got4;

   always_comb begin
      got2 = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            lin2[i][j] = (j == 0) ? l2[i*DW +: DW] : h2[i][(j == 0) ? 0 : j-1];
            uin2[i][j] = (i == 0) ? u2[j*DW +: DW] : v2[(i == 0) ? 0 : i-1][j];
            got2[(i*2+j)*64 +: 64] = res2[i][j];
         end
      end
   end

   always_comb begin
      got4 = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            lin4[i][j] = (j == 0) ? l4[i*DW +: DW] : h4[i][(j == 0) ? 0 : j-1];
            uin4[i][j] = (i == 0) ? u4[j*DW +: DW] : v4[(i == 0) ? 0 : i-1][j];
            got4[(i*4+j)*64 +: 64] = res4[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            res2[i][j] <= clr2 ? 64'd0 : res2[i][j] + 64'(lin2[i][j]) * 64'(uin2[i][j]);
            h2[i][j]   <= lin2[i][j];
            v2[i][j]   <= uin2[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            res4[i][j] <= clr4 ? 64'd0 : res4[i][j] + 64'(lin4[i][j]) * 64'(uin4[i][j]);
            h4[i][j]   <= lin4[i][j];
            v4[i][j]   <= uin4[i][j];
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [1023:0] sb2[$];
   logic [1023:0] sb4[$];

   typedef struct {
      logic          clr, busy, done, ready;
      logic [DW-1:0] l0, l1, u0, u1;
   } vec_t;
   vec_t vt [8];

   task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [1023:0] matmul(input int n, input logic [16*DW-1:0] a,
                                            input logic [16*DW-1:0] b);
      logic [1023:0] c;
      logic [63:0]   s;
      c = '0;
      for (int r = 0; r < n; r++) begin
         for (int cc = 0; cc < n; cc++) begin
            s = '0;
            for (int k = 0; k < n; k++)
               s += 64'(a[(r*n+k)*DW +: DW]) * 64'(b[(k*n+cc)*DW +: DW]);
            c[(r*n+cc)*64 +: 64] = s;
         end
      end
      return c;
   endfunction

   // Expected {clr,busy,done,ready,left,up} of the N=4 block, c cycles after acceptance.
   function automatic logic [1023:0] exp4(input int c, input logic [16*DW-1:0] a,
                                          input logic [16*DW-1:0] b);
      logic [4*DW-1:0] l, u;
      int t, d;
      l = '0;
      u = '0;
      if (c >= 1 && c <= 10) begin
         t = c - 1;
         for (int i = 0; i < 4; i++) begin
            d = t - i;
            if (d >= 0 && d < 4) begin
               l[i*DW +: DW] = a[(i*4+d)*DW +: DW];
               u[i*DW +: DW] = b[(d*4+i)*DW +: DW];
            end
         end
      end
      return 1024'({c == 0, c <= 11, c == 12, c >= 13, l, u});
   endfunction

   task automatic mon();
      logic [1023:0] e;
      if (dn2) begin
         if (sb2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done2_unexpected: got done_o=1 expected no pulse");
         end else begin
            e = sb2.pop_front();
            chk("res2", got2, e);
         end
      end
      if (dn4) begin
         if (sb4.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done4_unexpected: got done_o=1 expected no pulse");
         end else begin
            e = sb4.pop_front();
            chk("res4", got4, e);
         end
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         mon();
      end
   endtask

   // Runs one N=4 job for 16 cycles, optionally pulsing start during FEED and DONE.
   task automatic run4(input logic [16*DW-1:0] a, input logic [16*DW-1:0] b, input bit pulse);
      af4 = a;
      bf4 = b;
      s4  = 1'b1;
      sb4.push_back(matmul(4, a, b));
      for (int c = 0; c < 16; c++) begin
         step();
         if (c == 0) s4 = 1'b0;
         if (c == 1) begin
            af4 = {16{$urandom}};
            bf4 = {16{$urandom}};
         end
         chk($sformatf("n4_cycle%0d", c), 1024'({clr4, bsy4, dn4, rdy4, l4, u4}), exp4(c, a, b));
         if (pulse && (c == 3 || c == 12)) s4 = 1'b1;
         if (pulse && (c == 4 || c == 13)) s4 = 1'b0;
      end
   endtask

   task automatic job2(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
      af2 = a;
      bf2 = b;
      s2  = 1'b1;
      sb2.push_back(matmul(2, 512'(a), 512'(b)));
      step();
      s2 = 1'b0;
      step(7);
   endtask

   function automatic logic [16*DW-1:0] rnd16();
      logic [16*DW-1:0] m;
      for (int i = 0; i < 16; i++) m[i*DW +: DW] = DW'($urandom_range(0, 65535));
      return m;
   endfunction

   logic [16*DW-1:0] ma, mb;

   initial begin
      vt[0] = '{1, 1, 0, 0, 0, 0, 0, 0};
      vt[1] = '{0, 1, 0, 0, 1, 0, 5, 0};
      vt[2] = '{0, 1, 0, 0, 2, 3, 7, 6};
      vt[3] = '{0, 1, 0, 0, 0, 4, 0, 8};
      vt[4] = '{0, 1, 0, 0, 0, 0, 0, 0};
      vt[5] = '{0, 1, 0, 0, 0, 0, 0, 0};
      vt[6] = '{0, 0, 1, 0, 0, 0, 0, 0};
      vt[7] = '{0, 0, 0, 1, 0, 0, 0, 0};
      {s2, a2, s4, a4} = '0;
      {af2, bf2, af4, bf4} = '0;

      #1 rst_n = 1'b0;
      #3;
      chk("reset2", 1024'({rdy2, bsy2, dn2, clr2, l2, u2}), 1024'({4'b1000, 64'd0, 64'd0}));
      chk("reset4", 1024'({rdy4, bsy4, dn4, clr4, l4, u4}), 1024'({4'b1000, 128'd0, 128'd0}));
      step(2);
      #2 rst_n = 1'b1;
      step(3);

      // N=2 skew table; operand inputs are scrambled after acceptance.
      af2 = {32'd4, 32'd3, 32'd2, 32'd1};
      bf2 = {32'd8, 32'd7, 32'd6, 32'd5};
      s2  = 1'b1;
      sb2.push_back(matmul(2, 512'(af2), 512'(bf2)));
      for (int c = 0; c < 8; c++) begin
         step();
         if (c == 0) begin
            s2  = 1'b0;
            af2 = {4{$urandom}};
            bf2 = {4{$urandom}};
         end
         chk($sformatf("n2_skew%0d", c), 1024'({clr2, bsy2, dn2, rdy2, l2, u2}),
             1024'({vt[c].clr, vt[c].busy, vt[c].done, vt[c].ready,
                    vt[c].l1, vt[c].l0, vt[c].u1, vt[c].u0}));
      end

      // Identity x B after a previous job: accumulators must have been cleared.
      job2({32'd1, 32'd0, 32'd0, 32'd1}, {32'd6, 32'd7, 32'd8, 32'd9});

      // Start and abort together in IDLE: start wins.
      af2 = {32'd11, 32'd12, 32'd13, 32'd14};
      bf2 = {32'd3, 32'd5, 32'd7, 32'd9};
      s2  = 1'b1;
      a2  = 1'b1;
      sb2.push_back(matmul(2, 512'(af2), 512'(bf2)));
      step();
      chk("start_beats_abort", 1024'({clr2, bsy2}), 1024'(2'b11));
      s2 = 1'b0;
      a2 = 1'b0;
      step(7);

      // Reset mid-FEED: immediate idle outputs and no done afterwards.
      af2 = {32'd2, 32'd2, 32'd2, 32'd2};
      bf2 = af2;
      s2  = 1'b1;
      step();
      s2 = 1'b0;
      step(2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", 1024'({rdy2, bsy2, dn2, clr2, l2, u2}), 1024'({4'b1000, 64'd0, 64'd0}));
      step(2);
      #2 rst_n = 1'b1;
      step(10);
      chk("idle_after_reset", 1024'({rdy2, bsy2}), 1024'(2'b10));

      // N=4 latency with start pulses during FEED and DONE that must be ignored.
      run4(rnd16(), rnd16(), 1'b1);
      step(3);

      // Abort at FEED t=2, then a fresh job.
      ma = rnd16();
      mb = rnd16();
      af4 = ma;
      bf4 = mb;
      s4  = 1'b1;
      sb4.push_back(matmul(4, ma, mb));
      step();
      s4 = 1'b0;
      step(3);
      a4 = 1'b1;
      step();
      a4 = 1'b0;
      void'(sb4.pop_back());
      chk("abort_idle", 1024'({clr4, bsy4, dn4, rdy4, l4, u4}), exp4(99, ma, mb));
      step(14);
      chk("abort_stays_idle", 1024'({rdy4, bsy4}), 1024'(2'b10));
      run4(rnd16(), rnd16(), 1'b0);

      chk("sb2_drained", 1024'(sb2.size()), 1024'(0));
      chk("sb4_drained", 1024'(sb4.size()), 1024'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
